// File: rtl/snake_pkg.sv
// Shared state encoding, BCD digit type and default step periods for the
// snake game controller.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int unsigned TICK_SLOW_DEF = 5_000_000;
  localparam int unsigned TICK_FAST_DEF = 2_500_000;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and increment, saturating at 99.
module bcd2_counter
  import snake_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t tens_o,
  output bcd_t units_o
);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i && !(tens_q == 4'd9 && units_q == 4'd9)) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: step timing, BCD score/high score, status LEDs.
// Optional pause support is compiled in with `define SNAKE_CTRL_PAUSE_EN.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_SLOW = TICK_SLOW_DEF,
  parameter int unsigned TICK_FAST = TICK_FAST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef SNAKE_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       mode_fast,
  input  logic       eat,
  input  logic       collide,
  input  logic       high_clr,
  output logic       move_tick,
  output logic       clear_req,
  output logic [1:0] state,
  output logic [3:0] score1,
  output logic [3:0] score0,
  output logic [3:0] high1,
  output logic [3:0] high0,
  output logic       g_over,
  output logic       led_red,
  output logic       led_green,
  output logic       led_blue
);

  localparam int unsigned CNT_W = (TICK_SLOW > 2) ? $clog2(TICK_SLOW) : 1;
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(TICK_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(TICK_FAST - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_m1;
  logic [7:0]       high_q, high_d;
  logic             tick_hit;
  logic             act;
  logic             run_ok;
  logic             score_clr, score_inc;
  bcd_t             sc_tens, sc_units;

  logic move_tick_q, move_tick_d;
  logic clear_req_q, clear_req_d;
  logic g_over_q, g_over_d;
  logic led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;

  // act gates eat/collide; run_ok gates the step counter (counts on the
  // un-pausing cycle, holds on the pausing cycle).
`ifdef SNAKE_CTRL_PAUSE_EN
  logic paused_q, paused_d;

  always_comb begin
    paused_d = 1'b0;
    if (state_q == ST_PLAY) paused_d = paused_q ^ pause;
  end

  assign act    = (state_q == ST_PLAY) && !paused_q && !pause;
  assign run_ok = !paused_d;

  always_ff @(posedge clk) begin
    if (reset) paused_q <= 1'b0;
    else       paused_q <= paused_d;
  end
`else
  assign act    = (state_q == ST_PLAY);
  assign run_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_PLAY;
      ST_PLAY:  if (collide && act) state_d = ST_OVER;
      ST_OVER:  if (start) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign lim_m1 = mode_fast ? FAST_M1 : SLOW_M1;

  always_comb begin
    cnt_d    = cnt_q;
    tick_hit = 1'b0;
    if (state_d == ST_CLEAR) begin
      cnt_d = '0;
    end else if (state_q == ST_PLAY && state_d == ST_PLAY && run_ok) begin
      if (cnt_q >= lim_m1) begin
        tick_hit = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    move_tick_d = tick_hit;
    clear_req_d = (state_d == ST_CLEAR);
    g_over_d    = (state_d == ST_OVER);
    led_r_d     = (state_d == ST_OVER) || (state_d == ST_IDLE);
    led_g_d     = ((state_d == ST_PLAY) && !mode_fast) || (state_d == ST_IDLE);
    led_b_d     = ((state_d == ST_PLAY) && mode_fast) || (state_d == ST_IDLE);
  end

  assign score_clr = (state_d == ST_CLEAR);
  assign score_inc = eat && act && !collide;

  bcd2_counter u_score (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .tens_o  (sc_tens),
    .units_o (sc_units)
  );

  // BCD ordering matches binary ordering, so the packed digits compare directly.
  always_comb begin
    high_d = high_q;
    if (high_clr) begin
      high_d = '0;
    end else if (state_q == ST_PLAY && state_d == ST_OVER &&
                 {sc_tens, sc_units} > high_q) begin
      high_d = {sc_tens, sc_units};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      high_q      <= '0;
      move_tick_q <= 1'b0;
      clear_req_q <= 1'b0;
      g_over_q    <= 1'b0;
      led_r_q     <= 1'b1;
      led_g_q     <= 1'b1;
      led_b_q     <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      move_tick_q <= move_tick_d;
      clear_req_q <= clear_req_d;
      g_over_q    <= g_over_d;
      led_r_q     <= led_r_d;
      led_g_q     <= led_g_d;
      led_b_q     <= led_b_d;
    end
  end

  assign state     = state_q;
  assign score1    = sc_tens;
  assign score0    = sc_units;
  assign high1     = high_q[7:4];
  assign high0     = high_q[3:0];
  assign move_tick = move_tick_q;
  assign clear_req = clear_req_q;
  assign g_over    = g_over_q;
  assign led_red   = led_r_q;
  assign led_green = led_g_q;
  assign led_blue  = led_b_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl (TICK_SLOW=8, TICK_FAST=4).
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, mode_fast, eat, collide, high_clr;
`ifdef SNAKE_CTRL_PAUSE_EN
  logic       pause;
`endif
  logic       move_tick, clear_req, g_over;
  logic [1:0] state;
  logic [3:0] score1, score0, high1, high0;
  logic       led_red, led_green, led_blue;

  int tests = 0;
  int fails = 0;

  snake_game_ctrl #(.TICK_SLOW(8), .TICK_FAST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SNAKE_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .mode_fast (mode_fast),
    .eat       (eat),
    .collide   (collide),
    .high_clr  (high_clr),
    .move_tick (move_tick),
    .clear_req (clear_req),
    .state     (state),
    .score1    (score1),
    .score0    (score0),
    .high1     (high1),
    .high0     (high0),
    .g_over    (g_over),
    .led_red   (led_red),
    .led_green (led_green),
    .led_blue  (led_blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of cycles until move_tick is seen (0 if not within bound).
  task automatic wait_tick(input int exp, input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= exp + 4; i++) begin
      @(negedge clk);
      if (move_tick === 1'b1) begin
        n = i;
        break;
      end
    end
    chk(tag, 8'(n), 8'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic new_game();
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
  endtask

  initial begin
    int nt;
    reset = 1'b1; start = 1'b0; mode_fast = 1'b0;
    eat = 1'b0; collide = 1'b0; high_clr = 1'b0;
`ifdef SNAKE_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    cyc(2);
    chk("rst_state", {6'd0, state}, 8'h00);
    chk("rst_pulses", {5'd0, move_tick, clear_req, g_over}, 8'h00);
    chk("rst_score", {score1, score0}, 8'h00);
    chk("rst_high", {high1, high0}, 8'h00);
    chk("rst_leds", {5'd0, led_red, led_green, led_blue}, 8'h07);
    reset = 1'b0;

    eat = 1'b1; collide = 1'b1; cyc(1); eat = 1'b0; collide = 1'b0;
    chk("idle_ignore_state", {6'd0, state}, 8'h00);
    chk("idle_ignore_score", {score1, score0}, 8'h00);

    start = 1'b1; cyc(1); start = 1'b0;
    chk("clear_state", {6'd0, state}, 8'h01);
    chk("clear_pulse", {6'd0, move_tick, clear_req}, 8'h01);
    chk("clear_leds", {5'd0, led_red, led_green, led_blue}, 8'h00);
    cyc(1);
    chk("play_state", {6'd0, state}, 8'h02);
    chk("clear_drop", {7'd0, clear_req}, 8'h00);
    chk("slow_leds", {5'd0, led_red, led_green, led_blue}, 8'h02);
    wait_tick(8, "first_tick");
    cyc(1);
    chk("tick_single", {7'd0, move_tick}, 8'h00);
    cyc(5);
    mode_fast = 1'b1;
    wait_tick(1, "fast_switch");
    chk("fast_leds", {5'd0, led_red, led_green, led_blue}, 8'h01);
    wait_tick(4, "fast_period1");
    wait_tick(4, "fast_period2");
    mode_fast = 1'b0;

    eat = 1'b1;
    cyc(9);  chk("score_09", {score1, score0}, 8'h09);
    cyc(1);  chk("score_10", {score1, score0}, 8'h10);
    cyc(89); chk("score_99", {score1, score0}, 8'h99);
    cyc(6);  chk("score_sat", {score1, score0}, 8'h99);
    eat = 1'b0;
    collide = 1'b1; cyc(1); collide = 1'b0;
    chk("over_state", {6'd0, state}, 8'h03);
    chk("over_gover", {7'd0, g_over}, 8'h01);
    chk("over_leds", {5'd0, led_red, led_green, led_blue}, 8'h04);
    chk("over_high99", {high1, high0}, 8'h99);
    eat = 1'b1; cyc(1); eat = 1'b0;
    chk("over_eat_ignored", {score1, score0}, 8'h99);

    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_clear", {6'd0, state}, 8'h01);
    chk("restart_score", {score1, score0}, 8'h00);
    chk("restart_high", {high1, high0}, 8'h99);
    cyc(1);
    high_clr = 1'b1; cyc(1); high_clr = 1'b0;
    chk("high_clr_play", {high1, high0}, 8'h00);
    eat = 1'b1; cyc(12); eat = 1'b0;
    collide = 1'b1; cyc(1); collide = 1'b0;
    chk("high_12", {high1, high0}, 8'h12);

    new_game();
    eat = 1'b1; cyc(5);
    collide = 1'b1; cyc(1); eat = 1'b0; collide = 1'b0;
    chk("eat_collide_state", {6'd0, state}, 8'h03);
    chk("eat_collide_score", {score1, score0}, 8'h05);
    chk("eat_collide_high", {high1, high0}, 8'h12);

    new_game();
    eat = 1'b1; cyc(20); eat = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_in_play", {6'd0, state}, 8'h02);
    chk("start_in_play_score", {score1, score0}, 8'h20);
    collide = 1'b1; high_clr = 1'b1; cyc(1); collide = 1'b0; high_clr = 1'b0;
    chk("clr_beats_update", {high1, high0}, 8'h00);
    chk("clr_over_state", {6'd0, state}, 8'h03);

    new_game();
    eat = 1'b1; cyc(3); eat = 1'b0;
    reset = 1'b1; cyc(1);
    chk("rst_play_state", {6'd0, state}, 8'h00);
    chk("rst_play_score", {score1, score0}, 8'h00);
    chk("rst_play_leds", {5'd0, led_red, led_green, led_blue}, 8'h07);
    reset = 1'b0;

`ifdef SNAKE_CTRL_PAUSE_EN
    new_game();
    cyc(3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      eat = (i == 5);
      cyc(1);
      if (move_tick === 1'b1) nt++;
    end
    eat = 1'b0;
    chk("paused_no_tick", 8'(nt), 8'h00);
    chk("paused_eat_ignored", {score1, score0}, 8'h00);
    chk("paused_state", {6'd0, state}, 8'h02);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("resume_no_tick", {7'd0, move_tick}, 8'h00);
    wait_tick(4, "resume_tick");
    pause = 1'b1; collide = 1'b1; cyc(1); pause = 1'b0; collide = 1'b0;
    chk("collide_with_pause", {6'd0, state}, 8'h02);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_paused", {6'd0, state}, 8'h02);
    reset = 1'b1; cyc(1);
    chk("rst_pause_state", {6'd0, state}, 8'h00);
    chk("rst_pause_leds", {5'd0, led_red, led_green, led_blue}, 8'h07);
    reset = 1'b0;
`else
    nt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
